// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_pkg
// Description : Lamp encodings, phase codes and phase helpers shared by the
//               intersection controller and its timer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [2:0] {
    HWY_G  = 3'd0,
    HWY_Y  = 3'd1,
    ALLR_1 = 3'd2,
    ST_G   = 3'd3,
    ST_Y   = 3'd4,
    ALLR_2 = 3'd5
  } state_t;

  function automatic int unsigned state_dur(input state_t s,
                                            input int unsigned t_hwy_green,
                                            input int unsigned t_st_green,
                                            input int unsigned t_yellow,
                                            input int unsigned t_allred);
    case (s)
      HWY_G:          return t_hwy_green;
      HWY_Y, ST_Y:    return t_yellow;
      ALLR_1, ALLR_2: return t_allred;
      ST_G:           return t_st_green;
      default:        return t_hwy_green;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      HWY_G:   return HWY_Y;
      HWY_Y:   return ALLR_1;
      ALLR_1:  return ST_G;
      ST_G:    return ST_Y;
      ST_Y:    return ALLR_2;
      default: return HWY_G;
    endcase
  endfunction

  function automatic logic [1:0] hwy_lamp(input state_t s);
    case (s)
      HWY_G:   return LAMP_GREEN;
      HWY_Y:   return LAMP_YELLOW;
      default: return LAMP_RED;
    endcase
  endfunction

  function automatic logic [1:0] st_lamp(input state_t s);
    case (s)
      ST_G:    return LAMP_GREEN;
      ST_Y:    return LAMP_YELLOW;
      default: return LAMP_RED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl_if
// Description : Time base, demand and lamp signals of the intersection
//               controller. Pedestrian signals exist with TRAFFIC_LIGHT_PED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_light_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             street_req;
  logic [1:0]       highway;
  logic [1:0]       street;
  logic [2:0]       phase;
  logic [CNT_W-1:0] timer;
`ifdef TRAFFIC_LIGHT_PED_EN
  logic             ped_req;
  logic             walk;

  modport master (input tick, street_req, ped_req,
                  output highway, street, phase, timer, walk);
  modport slave  (output tick, street_req, ped_req,
                  input highway, street, phase, timer, walk);
`else
  modport master (input tick, street_req,
                  output highway, street, phase, timer);
  modport slave  (output tick, street_req,
                  input highway, street, phase, timer);
`endif
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter with tick enable; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_tick,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load wins over decrement so a phase change always starts a full interval.
  always_ff @(posedge clk) begin
    if (rst)
      r_count <= RST_VAL;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_tick && (r_count != '0))
      r_count <= r_count - 1'b1;
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Timed highway/street controller with all-red clearance and
//               demand-driven street service. Optional macro
//               TRAFFIC_LIGHT_PED_EN adds a pedestrian request and walk lamp.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int          CNT_W       = 8,
  parameter int unsigned T_HWY_GREEN = 20,
  parameter int unsigned T_ST_GREEN  = 10,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1
) (
  input wire logic              clk,
  input wire logic              rst,
  traffic_light_ctrl_if.master  bus
);

  state_t           r_state;
  logic             r_req_pend;
  logic [1:0]       r_highway;
  logic [1:0]       r_street;
  state_t           w_next;
  logic             w_load;
  logic             w_demand;
  logic             w_zero;
  logic [CNT_W-1:0] w_timer;
  logic [CNT_W-1:0] w_load_val;

  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    return CNT_W'(state_dur(s, T_HWY_GREEN, T_ST_GREEN, T_YELLOW, T_ALLRED) - 1);
  endfunction

`ifdef TRAFFIC_LIGHT_PED_EN
  logic r_ped_pend;
  logic r_walk;
  assign w_demand = r_req_pend | bus.street_req | r_ped_pend | bus.ped_req;
`else
  assign w_demand = r_req_pend | bus.street_req;
`endif

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      HWY_G: begin
        if (bus.tick && w_zero && w_demand) begin
          w_next = HWY_Y;
          w_load = 1'b1;
        end
      end
      HWY_Y, ALLR_1, ST_G, ST_Y, ALLR_2: begin
        if (bus.tick && w_zero) begin
          w_next = next_phase(r_state);
          w_load = 1'b1;
        end
      end
      // Codes 6/7 recover immediately, independent of tick.
      default: begin
        w_next = HWY_G;
        w_load = 1'b1;
      end
    endcase
  end

  assign w_load_val = dur_m1(w_next);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_HWY_GREEN - 1))
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (bus.tick),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_timer),
    .o_zero     (w_zero)
  );

  // Lamps are decoded from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HWY_G;
      r_req_pend <= 1'b0;
      r_highway  <= LAMP_GREEN;
      r_street   <= LAMP_RED;
`ifdef TRAFFIC_LIGHT_PED_EN
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
`endif
    end else begin
      r_state   <= w_next;
      r_highway <= hwy_lamp(w_next);
      r_street  <= st_lamp(w_next);
      if (w_load && (w_next == ST_G))
        r_req_pend <= 1'b0;
      else if (bus.street_req)
        r_req_pend <= 1'b1;
`ifdef TRAFFIC_LIGHT_PED_EN
      if (w_load && (w_next == ST_G)) begin
        r_ped_pend <= 1'b0;
        r_walk     <= r_ped_pend;
      end else begin
        if (bus.ped_req)
          r_ped_pend <= 1'b1;
        if (w_next != ST_G)
          r_walk <= 1'b0;
      end
`endif
    end
  end

  assign bus.highway = r_highway;
  assign bus.street  = r_street;
  assign bus.phase   = r_state;
  assign bus.timer   = w_timer;
`ifdef TRAFFIC_LIGHT_PED_EN
  assign bus.walk    = r_walk;
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Scoreboard bench for traffic_light_ctrl with short durations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;
  import traffic_light_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_ctrl_if #(.CNT_W(8)) bus();

  traffic_light_ctrl #(
    .CNT_W(8), .T_HWY_GREEN(4), .T_ST_GREEN(3), .T_YELLOW(2), .T_ALLRED(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef TRAFFIC_LIGHT_PED_EN
  initial bus.ped_req = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] hw;
    logic [1:0] st;
    logic [7:0] tm;
    logic       rq;
  } obs_t;

  obs_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_st, m_tm;
  bit   m_req;

  function automatic int dur(input int s);
    case (s)
      0: return 4;
      1: return 2;
      2: return 1;
      3: return 3;
      4: return 2;
      5: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.ph = 3'(m_st);
    o.hw = (m_st == 0) ? 2'b01 : (m_st == 1) ? 2'b10 : 2'b00;
    o.st = (m_st == 3) ? 2'b01 : (m_st == 4) ? 2'b10 : 2'b00;
    o.tm = 8'(m_tm);
    o.rq = m_req;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return {bus.phase, bus.highway, bus.street, bus.timer, dut.r_req_pend};
  endfunction

  // Drive one clock of stimulus, advance the reference model, queue its result.
  task automatic cycle(input bit r, input bit t, input bit s);
    rst = r; bus.tick = t; bus.street_req = s;
    if (r) begin
      m_st = 0; m_tm = 3; m_req = 0;
    end else if (m_st > 5) begin
      m_st = 0; m_tm = dur(0) - 1; m_req = m_req | s;
    end else if (t && m_tm == 0 && (m_st != 0 || m_req || s)) begin
      m_st  = (m_st + 1) % 6;
      m_tm  = dur(m_st) - 1;
      m_req = (m_st == 3) ? 1'b0 : (m_req | s);
    end else begin
      if (t && m_tm != 0) m_tm = m_tm - 1;
      m_req = m_req | s;
    end
    q.push_back(model_obs());
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (bus.highway != 2'b00 && bus.street != 2'b00) begin
        failures++;
        $display("FAIL safety hw=%b st=%b required one red", bus.highway, bus.street);
      end
    end
  end

  task automatic test_reset();
    obs_t e, a;
    cycle(1, 1, 1);
    e = q.pop_front(); a = dut_obs(); checks++;
    if (a !== e) begin
      failures++; $display("FAIL reset got=%h exp=%h", a, e);
    end
    checks++;
    if (a !== {3'd0, 2'b01, 2'b00, 8'd3, 1'b0}) begin
      failures++; $display("FAIL reset_const got=%h exp=%h", a, {3'd0, 2'b01, 2'b00, 8'd3, 1'b0});
    end
  endtask

  task automatic test_full_cycle();
    obs_t e, a;
    cycle(1, 1, 1);
    void'(q.pop_front());
    for (int i = 1; i <= 26; i++) begin
      cycle(0, 1, 1);
      e = q.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin
        failures++; $display("FAIL full_cycle i=%0d got=%h exp=%h", i, a, e);
      end
      if (i == 12 || i == 13) begin
        checks++;
        if (bus.phase !== ((i == 12) ? 3'd5 : 3'd0)) begin
          failures++; $display("FAIL period i=%0d phase=%0d", i, bus.phase);
        end
      end
    end
  endtask

  task automatic test_no_demand();
    obs_t e, a;
    cycle(1, 1, 0);
    void'(q.pop_front());
    for (int i = 0; i < 50; i++) begin
      cycle(0, 1, 0);
      e = q.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin
        failures++; $display("FAIL no_demand i=%0d got=%h exp=%h", i, a, e);
      end
    end
    cycle(0, 1, 1);
    e = q.pop_front(); a = dut_obs(); checks++;
    if (a !== e || bus.phase !== 3'd1) begin
      failures++; $display("FAIL demand_pulse got=%h exp=%h", a, e);
    end
    cycle(0, 1, 0);
    void'(q.pop_front());
  endtask

  task automatic test_slow_tick();
    obs_t e, a;
    cycle(1, 1, 0);
    void'(q.pop_front());
    for (int i = 0; i < 60; i++) begin
      cycle(0, (i % 4) == 3, 1);
      e = q.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin
        failures++; $display("FAIL slow_tick i=%0d got=%h exp=%h", i, a, e);
      end
    end
  endtask

  task automatic test_req_during_sty();
    obs_t e, a;
    bit   seen;
    cycle(1, 1, 0);
    void'(q.pop_front());
    cycle(0, 1, 1);
    void'(q.pop_front());
    for (int i = 0; i < 40 && m_st != 4; i++) begin
      cycle(0, 1, 0);
      e = q.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin
        failures++; $display("FAIL to_sty i=%0d got=%h exp=%h", i, a, e);
      end
    end
    checks++;
    if (bus.phase !== 3'd4) begin
      failures++; $display("FAIL reach_sty phase=%0d required 4", bus.phase);
    end
    cycle(0, 1, 1);
    void'(q.pop_front());
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0);
      e = q.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin
        failures++; $display("FAIL latched_req i=%0d got=%h exp=%h", i, a, e);
      end
      if (bus.phase === 3'd1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL latched_exit phase never 1 required HWY_Y");
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, a;
    cycle(1, 1, 1);
    void'(q.pop_front());
    for (int i = 0; i < 30 && !(m_st == 3 && m_tm == 1); i++) begin
      cycle(0, 1, 1);
      e = q.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin
        failures++; $display("FAIL to_stg i=%0d got=%h exp=%h", i, a, e);
      end
    end
    cycle(1, 1, 1);
    e = q.pop_front(); a = dut_obs(); checks++;
    if (a !== e || a !== {3'd0, 2'b01, 2'b00, 8'd3, 1'b0}) begin
      failures++; $display("FAIL reset_mid got=%h exp=%h", a, e);
    end
  endtask

  task automatic test_illegal();
    obs_t e, a;
    cycle(1, 1, 0);
    void'(q.pop_front());
    cycle(0, 1, 0);
    void'(q.pop_front());
    force dut.r_state = state_t'(3'd6);
    m_st = 6;
    #1;
    release dut.r_state;
    cycle(0, 1, 0);
    e = q.pop_front(); a = dut_obs(); checks++;
    if (a !== e) begin
      failures++; $display("FAIL illegal got=%h exp=%h", a, e);
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.street_req = 1'b0;
    test_reset();
    test_full_cycle();
    test_no_demand();
    test_slow_tick();
    test_req_during_sty();
    test_reset_mid();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
